// File: rtl/fpu_pkg.sv
// Shared FPU definitions: IEEE-754 single field widths, special encodings
// and the register layout of the normalise stage.
// No ports (package).
package fpu_pkg;

    localparam int FP_EXP_W   = 8;
    localparam int FP_FRAC_W  = 23;
    localparam int FP_MANT_W  = 27;
    localparam int FP_NORM_W  = 26;

    localparam logic [7:0]  FP_EXP_MAX = 8'd255;
    localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;
    localparam logic [31:0] FP_NEG_INF = 32'hFF80_0000;

    // Stage-1 register: normalised mantissa n[25]=hidden, n[24:2]=fraction,
    // n[1]=guard, n[0]=round; e is 9 bits so a carry past 255 stays visible.
    typedef struct packed {
        logic        valid;
        logic        zero;
        logic        sign;
        logic [8:0]  e;
        logic [25:0] n;
        logic        sticky;
        logic [4:0]  dest;
    } fpu_norm_t;

    // Signed infinity encoding.
    function automatic logic [31:0] fp_inf(input logic sign);
        logic [31:0] inf_v;
        if (sign) begin
            inf_v = FP_NEG_INF;
        end else begin
            inf_v = FP_POS_INF;
        end
        return inf_v;
    endfunction

endpackage

// File: rtl/fpu_normalize_if.sv
// Bus between the align/add stage, the normalise/round stage and writeback.
//   add_*        : unnormalised sum from the align/add stage
//   fpu_result_* : packed single-precision result towards writeback
// slave modport = normalise stage, master modport = its environment.
interface fpu_normalize_if #(
    parameter int MANT_W = 27,
    parameter int EXP_W  = 8
);
    logic              add_valid;
    logic [MANT_W-1:0] add_mantissa;
    logic [EXP_W-1:0]  add_exponent;
    logic              add_sign;
    logic [4:0]        add_dest;

    logic              fpu_result_valid;
    logic [31:0]       fpu_result;
    logic [4:0]        fpu_result_dest;
    logic              fpu_inexact;
    logic              fpu_overflow;

    modport slave (
        input  add_valid, add_mantissa, add_exponent, add_sign, add_dest,
        output fpu_result_valid, fpu_result, fpu_result_dest, fpu_inexact, fpu_overflow
    );

    modport master (
        output add_valid, add_mantissa, add_exponent, add_sign, add_dest,
        input  fpu_result_valid, fpu_result, fpu_result_dest, fpu_inexact, fpu_overflow
    );
endinterface

// File: rtl/fpu_lzc27.sv
// Leading-zero counter over a 26-bit mantissa field.
//   data  : 26-bit value, bit 25 is the most significant
//   count : number of leading zeros, 26 when data is all zero
module fpu_lzc27 (
    input  logic [25:0] data,
    output logic [4:0]  count
);

    // Scan upward so the highest set bit is the last one to write count.
    always_comb begin
        count = 5'd26;
        for (int i = 0; i < 26; i++) begin
            if (data[i]) begin
                count = 5'(25 - i);
            end else begin
                count = count;
            end
        end
    end

endmodule

// File: rtl/fpu_normalize.sv
// FPU add/sub second stage: normalise, round-to-nearest-even, pack single.
//   clock, resetn : clock and asynchronous active-low reset
//   bus (slave)   : add_* sum in, fpu_result_* packed result out
// Fixed two-cycle latency, one op per cycle, no stall.
module fpu_normalize
    import fpu_pkg::*;
(
    input  logic           clock,
    input  logic           resetn,
    fpu_normalize_if.slave bus
);

    logic [4:0]  lz_s;
    logic [7:0]  limit_s;
    logic [7:0]  shift_s;
    fpu_norm_t   norm_s;
    fpu_norm_t   norm_r;

    logic        rnd_s;
    logic [24:0] sum_s;
    logic [22:0] frac_s;
    logic        hidden_s;
    logic [8:0]  e_rnd_s;
    logic [7:0]  exp_field_s;
    logic [31:0] result_s;
    logic        inexact_s;
    logic        overflow_s;

    logic        result_valid_r;
    logic [31:0] result_r;
    logic [4:0]  dest_r;
    logic        inexact_r;
    logic        overflow_r;

    fpu_lzc27 u_lzc (
        .data  (bus.add_mantissa[25:0]),
        .count (lz_s)
    );

    // Stage 1: shift the sum so the hidden bit lands on n[25], never
    // pushing the exponent below 1 (that is where subnormals live).
    always_comb begin
        norm_s        = {$bits(fpu_norm_t){1'b0}};
        norm_s.valid  = bus.add_valid;
        norm_s.sign   = bus.add_sign;
        norm_s.dest   = bus.add_dest;
        if (bus.add_exponent == 8'd0) begin
            limit_s = 8'd0;
        end else begin
            limit_s = bus.add_exponent - 8'd1;
        end
        if ({3'd0, lz_s} < limit_s) begin
            shift_s = {3'd0, lz_s};
        end else begin
            shift_s = limit_s;
        end
        if (bus.add_exponent == FP_EXP_MAX) begin
            // Infinite operand: force the overflow path downstream.
            norm_s.e = 9'd255;
        end else if (bus.add_mantissa == 27'd0) begin
            norm_s.zero = 1'b1;
        end else if (bus.add_mantissa[26]) begin
            norm_s.n      = bus.add_mantissa[26:1];
            norm_s.e      = {1'b0, bus.add_exponent} + 9'd1;
            norm_s.sticky = bus.add_mantissa[0];
        end else begin
            norm_s.n = bus.add_mantissa[25:0] << shift_s[4:0];
            norm_s.e = {1'b0, bus.add_exponent} - {1'b0, shift_s};
        end
    end

    // Stage-1 pipeline register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            norm_r <= {$bits(fpu_norm_t){1'b0}};
        end else begin
            norm_r <= norm_s;
        end
    end

    // Stage 2: round to nearest-even and pack; a carry out of the
    // significand bumps the exponent, a subnormal that rounds into bit 23
    // becomes exponent 1 through the hidden bit.
    always_comb begin
        rnd_s     = norm_r.n[1] & (norm_r.n[0] | norm_r.sticky | norm_r.n[2]);
        sum_s     = {1'b0, norm_r.n[25:2]} + {24'd0, rnd_s};
        inexact_s = norm_r.n[1] | norm_r.n[0] | norm_r.sticky;
        if (sum_s[24]) begin
            frac_s   = 23'd0;
            hidden_s = 1'b1;
            e_rnd_s  = norm_r.e + 9'd1;
        end else begin
            frac_s   = sum_s[22:0];
            hidden_s = sum_s[23];
            e_rnd_s  = norm_r.e;
        end
        if (hidden_s) begin
            exp_field_s = e_rnd_s[7:0];
        end else begin
            exp_field_s = 8'd0;
        end
        if (norm_r.zero) begin
            result_s   = 32'h0000_0000;
            inexact_s  = 1'b0;
            overflow_s = 1'b0;
        end else if (e_rnd_s >= {1'b0, FP_EXP_MAX}) begin
            result_s   = fp_inf(norm_r.sign);
            inexact_s  = 1'b1;
            overflow_s = 1'b1;
        end else begin
            result_s   = {norm_r.sign, exp_field_s, frac_s};
            overflow_s = 1'b0;
        end
    end

    // Output register stage.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            result_valid_r <= 1'b0;
            result_r       <= 32'd0;
            dest_r         <= 5'd0;
            inexact_r      <= 1'b0;
            overflow_r     <= 1'b0;
        end else begin
            result_valid_r <= norm_r.valid;
            result_r       <= result_s;
            dest_r         <= norm_r.dest;
            inexact_r      <= inexact_s;
            overflow_r     <= overflow_s;
        end
    end

    assign bus.fpu_result_valid = result_valid_r;
    assign bus.fpu_result       = result_r;
    assign bus.fpu_result_dest  = dest_r;
    assign bus.fpu_inexact      = inexact_r;
    assign bus.fpu_overflow     = overflow_r;

endmodule

// File: tb/tb_fpu_normalize.sv
// Scoreboard bench for fpu_normalize: directed vectors with hand-derived
// results, randomized ops against an arithmetic reference model, and a
// reset-while-busy scenario.
module tb_fpu_normalize;

    logic clock = 1'b0;
    logic resetn;
    always #5 clock = ~clock;

    fpu_normalize_if bus ();

    fpu_normalize dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        int          cyc;
        logic [31:0] res;
        logic [4:0]  dest;
        logic        inx;
        logic        ovf;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_x;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   seen_valid = 0;
    int   seen_before;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: value = m * 2^(exp-127-25); pick the result exponent,
    // drop the excess low bits and round half to even on the integer.
    function automatic void ref_model(input logic [26:0] m, input logic [7:0] e,
                                      input logic s, output logic [31:0] res,
                                      output logic inx, output logic ovf);
        int p;
        int big_e;
        int d;
        longint unsigned q;
        longint unsigned r;
        longint unsigned half;
        if (e == 8'd255) begin
            res = {s, 8'hFF, 23'd0}; inx = 1'b1; ovf = 1'b1;
            return;
        end
        if (m == 27'd0) begin
            res = 32'd0; inx = 1'b0; ovf = 1'b0;
            return;
        end
        p = 0;
        for (int i = 0; i < 27; i++) if (m[i]) p = i;
        big_e = int'(e) + p - 25;
        if (big_e < 1) big_e = 1;
        d = big_e - int'(e) + 2;
        r = 0;
        if (d <= 0) begin
            q = longint'(m) << (-d);
        end else begin
            q    = longint'(m) >> d;
            r    = longint'(m) & ((longint'(1) << d) - 1);
            half = longint'(1) << (d - 1);
            if (r > half || (r == half && q[0])) q = q + 1;
        end
        inx = (r != 0);
        if (q >= 64'd16777216) begin
            q = q >> 1;
            big_e++;
        end
        if (big_e >= 255) begin
            res = {s, 8'hFF, 23'd0}; inx = 1'b1; ovf = 1'b1;
        end else begin
            res = {s, (q >= 64'd8388608) ? 8'(big_e) : 8'd0, q[22:0]};
            ovf = 1'b0;
        end
    endfunction

    task automatic drive(input logic [26:0] m, input logic [7:0] e, input logic s, input logic [4:0] d);
        @(posedge clock);
        #1;
        bus.add_valid    = 1'b1;
        bus.add_mantissa = m;
        bus.add_exponent = e;
        bus.add_sign     = s;
        bus.add_dest     = d;
    endtask

    task automatic send(input logic [26:0] m, input logic [7:0] e, input logic s, input logic [4:0] d,
                        input logic [31:0] res, input logic inx, input logic ovf);
        exp_t x;
        drive(m, e, s, d);
        x.cyc = cyc; x.res = res; x.dest = d; x.inx = inx; x.ovf = ovf;
        sb_q.push_back(x);
    endtask

    task automatic send_rand(input logic [26:0] m, input logic [7:0] e, input logic s, input logic [4:0] d);
        logic [31:0] res;
        logic inx;
        logic ovf;
        ref_model(m, e, s, res, inx, ovf);
        send(m, e, s, d, res, inx, ovf);
    endtask

    task automatic idle();
        @(posedge clock);
        #1;
        bus.add_valid    = 1'b0;
        bus.add_mantissa = 27'($urandom);
        bus.add_exponent = 8'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clock);
        @(negedge clock);
        chk("drain", 32'(sb_q.size()), 32'd0);
    endtask

    // Monitor: every presented result must match the oldest expectation.
    always @(negedge clock) begin
        if (resetn && bus.fpu_result_valid) begin
            seen_valid++;
            if (sb_q.size() == 0) begin
                chk("spurious_valid", 32'd1, 32'd0);
            end else begin
                mon_x = sb_q.pop_front();
                chk("result",   bus.fpu_result, mon_x.res);
                chk("dest",     {27'd0, bus.fpu_result_dest}, {27'd0, mon_x.dest});
                chk("inexact",  {31'd0, bus.fpu_inexact}, {31'd0, mon_x.inx});
                chk("overflow", {31'd0, bus.fpu_overflow}, {31'd0, mon_x.ovf});
                chk("latency",  32'(cyc), 32'(mon_x.cyc + 2));
            end
        end
    end

    initial begin
        logic [26:0] m;
        logic [7:0]  e;
        logic [31:0] mask;
        int w;

        resetn           = 1'b0;
        bus.add_valid    = 1'b0;
        bus.add_mantissa = 27'd0;
        bus.add_exponent = 8'd0;
        bus.add_sign     = 1'b0;
        bus.add_dest     = 5'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_outputs", {bus.fpu_result_valid, bus.fpu_result[30:0]}, 32'd0);
        chk("reset_flags", {25'd0, bus.fpu_result[31], bus.fpu_result_dest, bus.fpu_inexact, bus.fpu_overflow}, 32'd0);
        @(posedge clock);
        #2 resetn = 1'b1;

        // Directed vectors, issued back to back.
        send(27'h4000000, 8'd127, 1'b0, 5'd7,  32'h4000_0000, 1'b0, 1'b0);
        send(27'h0000004, 8'd127, 1'b0, 5'd1,  32'h3400_0000, 1'b0, 1'b0);
        send(27'h0000000, 8'd100, 1'b0, 5'd2,  32'h0000_0000, 1'b0, 1'b0);
        send(27'h2000002, 8'd127, 1'b0, 5'd3,  32'h3F80_0000, 1'b1, 1'b0);
        send(27'h2000006, 8'd127, 1'b0, 5'd4,  32'h3F80_0002, 1'b1, 1'b0);
        send(27'h3FFFFFE, 8'd127, 1'b0, 5'd5,  32'h4000_0000, 1'b1, 1'b0);
        send(27'h4000000, 8'd254, 1'b1, 5'd6,  32'hFF80_0000, 1'b1, 1'b1);
        send(27'h0800000, 8'd1,   1'b0, 5'd8,  32'h0020_0000, 1'b0, 1'b0);
        send(27'h1FFFFFE, 8'd1,   1'b0, 5'd9,  32'h0080_0000, 1'b1, 1'b0);
        send(27'h2000000, 8'd255, 1'b0, 5'd10, 32'h7F80_0000, 1'b1, 1'b1);
        send(27'h2000000, 8'd200, 1'b1, 5'd31, 32'hE400_0000, 1'b0, 1'b0);
        idle();
        drain();

        // Randomized ops with occasional bubbles.
        for (int k = 0; k < 400; k++) begin
            w    = $urandom_range(0, 27);
            mask = (32'd1 << w) - 32'd1;
            m    = 27'($urandom & mask);
            case ($urandom_range(0, 5))
                0:       e = 8'd1;
                1:       e = 8'($urandom_range(253, 255));
                default: e = 8'($urandom_range(1, 255));
            endcase
            if ($urandom_range(0, 3) == 0) idle();
            send_rand(m, e, 1'($urandom), 5'($urandom));
        end
        idle();
        drain();

        // Reset while two ops are in flight: both must vanish.
        drive(27'h4000000, 8'd127, 1'b0, 5'd11);
        drive(27'h2000000, 8'd127, 1'b0, 5'd12);
        #3;
        resetn        = 1'b0;
        bus.add_valid = 1'b0;
        sb_q.delete();
        seen_before   = seen_valid;
        @(negedge clock);
        chk("reset_busy_valid", {31'd0, bus.fpu_result_valid}, 32'd0);
        @(posedge clock);
        #4 resetn = 1'b1;
        repeat (4) @(posedge clock);
        @(negedge clock);
        chk("no_valid_after_reset", 32'(seen_valid), 32'(seen_before));

        send(27'h4000000, 8'd127, 1'b1, 5'd13, 32'hC000_0000, 1'b0, 1'b0);
        idle();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fpu_normalize.md
Name: fpu_normalize

Overview:
- Second FPU add/sub pipeline stage, directly downstream of the align/add stage.
- Takes the raw 27-bit signed-magnitude sum (carry, hidden, 23 fraction, guard, round bits) with biased exponent.
- Normalises, rounds to nearest-even and packs an IEEE-754 single.
- Result goes to the FPU writeback along with the destination register.
- Fully pipelined: one op per cycle, fixed 2-cycle latency, no stall.

Parameters:
- MANT_W, 27, width of incoming mantissa (bit26 carry, bit25 hidden, bits24:2 fraction, bits1:0 guard/round)
- EXP_W, 8, width of biased exponent

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- add_valid  in  1  operation present on this cycle
- add_mantissa  in  27  unnormalised magnitude sum
- add_exponent  in  8  biased exponent of larger operand (1 for subnormal)
- add_sign  in  1  result sign (already 0 for exact zero)
- add_dest  in  5  destination register
- fpu_result_valid  out  1  packed result valid
- fpu_result  out  32  IEEE-754 single result
- fpu_result_dest  out  5  destination register
- fpu_inexact  out  1  result was rounded (guard/round/sticky nonzero)
- fpu_overflow  out  1  result saturated to infinity

Behaviour:
- Reset: clock and reset are fixed as stated above (port names clock and resetn).
  - All pipeline flops and outputs clear to 0 asynchronously while resetn=0.
  - Ops in flight at reset are discarded; no spurious valid after release.
- Latency: add_valid at cycle N gives fpu_result_valid at N+2. Back-to-back valids give back-to-back results.
- Data flops capture regardless of valid; outputs are only meaningful when fpu_result_valid=1.
- Stage 1 (normalise), registered:
  - Exponent is carried as 9-bit unsigned e.
  - If m==0: zero flag set, e=0.
  - If m[26]=1: n = m>>1, e = add_exponent+1, sticky = m[0].
  - Else lz = leading zeros of m[25:0] (0..25); shift = min(lz, add_exponent-1); n = m<<shift; e = add_exponent-shift; sticky = 0.
  - n is 26 bits: n[25] hidden, n[24:2] fraction, n[1] guard, n[0] round.
  - Sign, dest, valid and zero flag are piped alongside.
- Stage 2 (round/pack), registered to outputs:
  - Rounding increment: rnd = n[1] & (n[0] | sticky | n[2]).
  - s = {1'b0, n[25:2]} + rnd (25 bits).
  - If s[24]=1: fraction = 0, e = e+1. Otherwise fraction = s[22:0]; hidden = s[23].
  - Exponent field = hidden ? e : 0. This gives the subnormal encoding; a subnormal that rounds up to bit23 naturally becomes exponent 1.
  - fpu_inexact = n[1] | n[0] | sticky.
  - If e >= 255 after rounding: fpu_result = {sign, 8'hFF, 23'h0}, fpu_overflow = 1, fpu_inexact = 1.
  - Zero flag: fpu_result = 32'h00000000, flags 0.
- Input exponent 255 (Inf operand) always yields ±Inf with overflow=1. NaN propagation is out of scope for this stage.
- No internal state beyond the two pipeline registers; every cycle is independent.

Decomposition:
- fpu_pkg:
  - field widths (FP_EXP_W=8, FP_FRAC_W=23, FP_MANT_W=27)
  - FP_EXP_MAX=255
  - FP_POS_INF/FP_NEG_INF constants
  - typedef fpu_norm_t {valid, zero, sign, e[8:0], n[25:0], sticky, dest[4:0]} for the stage-1 register
- Sub-module fpu_lzc27: combinational leading-zero counter over 26 bits, 5-bit count, output 26 for all-zero. Reusable by the multiply and convert paths.

Test Plan:
- 1.0+1.0: mantissa 27'h4000000, exp 127, sign 0 → after exactly 2 cycles 0x40000000, inexact=0, overflow=0, dest echoed.
- Cancellation and zero:
  - mantissa 27'h0000004, exp 127 → 0x34000000.
  - mantissa 0, exp 100 → 0x00000000, flags 0.
- Round-nearest-even:
  - 27'h2000002, exp 127 → 0x3F800000 with inexact=1.
  - 27'h2000006, exp 127 → 0x3F800002 with inexact=1.
  - 27'h3FFFFFE, exp 127 → 0x40000000.
- Overflow: 27'h4000000, exp 254, sign 1 → 0xFF800000, overflow=1, inexact=1.
- Subnormal: 27'h0800000, exp 1 → 0x00200000 (shift clamped, exponent field 0).
- Pipeline and reset:
  - Three consecutive valids with dests 1,2,3 → three consecutive results, order preserved.
  - resetn low for one cycle while two ops are in flight → no result valid emitted.
  - Next valid after release returns at +2.
